// File: rtl/sinegen_pkg.sv
// Shared types and defaults for the DDS address sequencer.
package sinegen_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH     = 16;

  // Sequencer states: stopped, free-running, running with a new setting
  // parked until the next phase wrap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Increment that advances the ROM address by exactly one entry per step.
  function automatic int incr_reset(input int acc_width, input int address_width);
    return 1 << (acc_width - address_width);
  endfunction

endpackage

// File: rtl/sinegen_ctrl_if.sv
// Configuration handshake bundle: a new phase increment and port-1 offset
// offered with valid/ready.
interface sinegen_ctrl_if
  import sinegen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int ACC_WIDTH     = DEFAULT_ACC_WIDTH
);
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [ACC_WIDTH-1:0]     cfg_incr;
  logic [ADDRESS_WIDTH-1:0] cfg_offset;

  // Configuration source
  modport master (
    output cfg_valid,
    output cfg_incr,
    output cfg_offset,
    input  cfg_ready
  );

  // Sequencer side
  modport slave (
    input  cfg_valid,
    input  cfg_incr,
    input  cfg_offset,
    output cfg_ready
  );

endinterface

// File: rtl/sinegen_ctrl_phase_acc.sv
// Phase accumulator: registered acc with an adder whose carry-out marks a
// phase wrap. clear has priority over step; otherwise acc holds.
module phase_acc
  import sinegen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int ACC_WIDTH     = DEFAULT_ACC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step,
  input  logic                     clear,
  input  logic [ACC_WIDTH-1:0]     incr,
  output logic [ADDRESS_WIDTH-1:0] phase,
  output logic                     carry,
  output logic                     wrap
);

  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] sum;
  logic                 wrap_reg;

  assign {carry, sum} = {1'b0, acc_reg} + {1'b0, incr};
  assign phase        = acc_reg[ACC_WIDTH-1 -: ADDRESS_WIDTH];
  assign wrap         = wrap_reg;

  // Advance, clear or hold the accumulator; flag a wrap only on stepped adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= step && carry;
      if (clear) begin
        acc_reg <= '0;
      end else if (step) begin
        acc_reg <= sum;
      end
    end
  end

endmodule

// File: rtl/sinegen_ctrl.sv
// DDS sequencer driving both address ports of a dual-port sine ROM.
// Port 1 runs at a configurable phase offset from port 0. New settings are
// accepted over valid/ready and, while running, parked in shadow registers
// until the accumulator wraps so the output never jumps mid-cycle.
module sinegen_ctrl
  import sinegen_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int                   ACC_WIDTH     = DEFAULT_ACC_WIDTH,  // must be >= ADDRESS_WIDTH
  parameter logic [ACC_WIDTH-1:0] INCR_RESET    = ACC_WIDTH'(incr_reset(ACC_WIDTH, ADDRESS_WIDTH))
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  sinegen_ctrl_if.slave            cfg,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic                     dout_valid,
  output logic                     wrap
);

  state_t                   state_reg;
  state_t                   state_next;
  logic [ACC_WIDTH-1:0]     incr_reg;
  logic [ADDRESS_WIDTH-1:0] offset_reg;
  logic [ACC_WIDTH-1:0]     shadow_incr_reg;
  logic [ADDRESS_WIDTH-1:0] shadow_offset_reg;
  logic                     dout_valid_reg;

  logic cfg_ready;
  logic transfer;
  logic step;
  logic clear;
  logic carry;
  logic load_direct;   // take the handshake values straight into incr/offset
  logic apply_shadow;  // move parked values into incr/offset
  logic load_shadow;   // park the handshake values

  assign cfg_ready     = !rst && (state_reg != PEND);
  assign cfg.cfg_ready = cfg_ready;
  assign transfer      = cfg.cfg_valid && cfg_ready;

  phase_acc #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_phase_acc (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .clear(clear),
    .incr (incr_reg),
    .phase(addr),
    .carry(carry),
    .wrap (wrap)
  );

  assign addr1      = addr + offset_reg;
  assign dout_valid = dout_valid_reg;

  // Next-state and control decode. A stopped sequencer applies settings at
  // once and restarts from phase 0; a running one defers them to the wrap.
  always_comb begin
    state_next   = state_reg;
    step         = 1'b0;
    clear        = 1'b0;
    load_direct  = 1'b0;
    apply_shadow = 1'b0;
    load_shadow  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (transfer) begin
          load_direct = 1'b1;
          clear       = 1'b1;
        end
        if (en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          // Stopping with a request in flight: no wrap will come, apply now.
          state_next = IDLE;
          if (transfer) begin
            load_shadow = 1'b1;
            load_direct = 1'b1;
            clear       = 1'b1;
          end
        end else begin
          step = 1'b1;
          if (transfer) begin
            load_shadow = 1'b1;
            state_next  = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          state_next   = IDLE;
          apply_shadow = 1'b1;
          clear        = 1'b1;
        end else begin
          step = 1'b1;
          // This add still uses the old increment; the new one starts next step.
          if (carry) begin
            apply_shadow = 1'b1;
            state_next   = RUN;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, active/shadow settings and the ROM-latency-aligned valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      incr_reg          <= INCR_RESET;
      offset_reg        <= '0;
      shadow_incr_reg   <= '0;
      shadow_offset_reg <= '0;
      dout_valid_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dout_valid_reg <= step;
      if (load_shadow) begin
        shadow_incr_reg   <= cfg.cfg_incr;
        shadow_offset_reg <= cfg.cfg_offset;
      end
      if (load_direct) begin
        incr_reg   <= cfg.cfg_incr;
        offset_reg <= cfg.cfg_offset;
      end else if (apply_shadow) begin
        incr_reg   <= shadow_incr_reg;
        offset_reg <= shadow_offset_reg;
      end
    end
  end

endmodule

// File: tb/tb_sinegen_ctrl.sv
// Bench for sinegen_ctrl: behavioural model checked every cycle, plus
// hand-computed pins along a directed scenario.
module tb_sinegen_ctrl;

  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr1;
  logic          dout_valid;
  logic          wrap;

  sinegen_ctrl_if #(.ADDRESS_WIDTH(AW), .ACC_WIDTH(CW)) cfg_bus ();

  sinegen_ctrl #(.ADDRESS_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg_bus),
    .addr      (addr),
    .addr1     (addr1),
    .dout_valid(dout_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit checking = 1'b0;

  // Model state: plain integers for phase and settings, two flags for mode.
  int m_acc, m_incr, m_offset, m_sh_incr, m_sh_offset;
  bit m_running, m_pending, m_dv, m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h, need %0h", name, $time, act, exp);
    end
  endtask

  // Model update from the rules: phase wraps modulo 2**16, settings apply
  // immediately when stopped and at the wrap when running.
  always @(posedge clk) begin : model
    int sum;
    bit cy;
    bit xfer;
    if (rst) begin
      m_acc = 0; m_incr = 256; m_offset = 0; m_sh_incr = 0; m_sh_offset = 0;
      m_running = 0; m_pending = 0; m_dv = 0; m_wrap = 0;
    end else begin
      xfer   = cfg_bus.cfg_valid && !m_pending;
      sum    = m_acc + m_incr;
      cy     = (sum >= 65536);
      m_dv   = en && m_running;
      m_wrap = m_dv && cy;
      if (!m_running) begin
        if (xfer) begin
          m_incr = int'(cfg_bus.cfg_incr); m_offset = int'(cfg_bus.cfg_offset); m_acc = 0;
        end
        m_running = en;
      end else if (!en) begin
        if (m_pending) begin
          m_incr = m_sh_incr; m_offset = m_sh_offset; m_acc = 0;
        end else if (xfer) begin
          m_sh_incr = int'(cfg_bus.cfg_incr); m_sh_offset = int'(cfg_bus.cfg_offset);
          m_incr = m_sh_incr; m_offset = m_sh_offset; m_acc = 0;
        end
        m_running = 0;
        m_pending = 0;
      end else begin
        m_acc = sum % 65536;
        if (m_pending) begin
          if (cy) begin
            m_incr = m_sh_incr; m_offset = m_sh_offset; m_pending = 0;
          end
        end else if (xfer) begin
          m_sh_incr = int'(cfg_bus.cfg_incr); m_sh_offset = int'(cfg_bus.cfg_offset);
          m_pending = 1;
        end
      end
    end
  end

  // Compare DUT against the model one step after every active edge.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("addr",       32'(addr),              32'(m_acc / 256));
      chk("addr1",      32'(addr1),             32'(((m_acc / 256) + m_offset) % 256));
      chk("dout_valid", 32'(dout_valid),        32'(m_dv));
      chk("wrap",       32'(wrap),              32'(m_wrap));
      chk("cfg_ready",  32'(cfg_bus.cfg_ready), 32'(!rst && !m_pending));
    end
  end

  // One clock: drive inputs on the falling edge, return after outputs settle.
  task automatic cyc(input bit r, input bit e, input bit v, input int inc, input int off);
    @(negedge clk);
    rst               = r;
    en                = e;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_incr  = CW'(inc);
    cfg_bus.cfg_offset = AW'(off);
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string name, input int a, input int a1, input bit dv,
                     input bit wr, input bit rdy);
    chk({name, ".addr"},  32'(addr),              32'(a));
    chk({name, ".addr1"}, 32'(addr1),             32'(a1));
    chk({name, ".dv"},    32'(dout_valid),        32'(dv));
    chk({name, ".wrap"},  32'(wrap),              32'(wr));
    chk({name, ".ready"}, 32'(cfg_bus.cfg_ready), 32'(rdy));
  endtask

  initial begin
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_incr   = '0;
    cfg_bus.cfg_offset = '0;
    checking = 1'b1;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    pin("reset", 0, 0, 0, 0, 0);

    // Default increment: one ROM entry per step, first en cycle leaves IDLE
    repeat (4) cyc(0, 1, 0, 0, 0);
    pin("defaults", 3, 3, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    pin("pause", 3, 3, 0, 0, 1);

    // Load in IDLE: applied at once, phase restarts
    cyc(0, 0, 1, 16'h4000, 64);  pin("idle_load", 0, 64, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("start", 0, 64, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("q1", 64, 128, 1, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("q2", 128, 192, 1, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("q3", 192, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("q4wrap", 0, 64, 1, 1, 1);
    cyc(0, 1, 0, 0, 0);          pin("q5", 64, 128, 1, 0, 1);

    // Load while running: deferred to next wrap
    cyc(0, 1, 1, 16'h8000, 64);  pin("run_load", 128, 192, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("pend1", 192, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("apply", 0, 64, 1, 1, 1);
    cyc(0, 1, 0, 0, 0);          pin("half1", 128, 192, 1, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("half2", 0, 64, 1, 1, 1);

    // Back to quarter steps, then a load on the very cycle a wrap fires
    cyc(0, 1, 1, 16'h4000, 0);   pin("reload", 128, 192, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("reapply", 0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("at_c000", 192, 192, 1, 0, 1);
    cyc(0, 1, 1, 16'h1000, 16);  pin("load_on_wrap", 0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0);          pin("held1", 64, 64, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("held3", 192, 192, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("late_apply", 0, 16, 1, 1, 1);
    cyc(0, 1, 0, 0, 0);          pin("new_rate", 16, 32, 1, 0, 1);

    // PEND then en drop: apply immediately, phase to 0
    cyc(0, 1, 1, 16'h2000, 5);   pin("pend_b", 32, 48, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);          pin("stop_apply", 0, 5, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("restart", 0, 5, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("step2000", 32, 37, 1, 0, 1);

    // en falling together with a transfer in RUN
    cyc(0, 0, 1, 16'h0400, 200); pin("fall_xfer", 0, 200, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("step400", 4, 204, 1, 0, 1);

    // PEND then reset: shadow discarded
    cyc(0, 1, 1, 16'h8000, 9);   pin("pend_c", 8, 208, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);          pin("mid_reset", 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("post_rst", 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("post_rst1", 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 0);          pin("post_rst2", 2, 2, 1, 0, 1);

    // Zero increment: no motion, no wrap, PEND persists until en drops
    cyc(0, 0, 1, 0, 0);          pin("zero_load", 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);          pin("zero_run", 0, 0, 1, 0, 1);
    cyc(0, 1, 1, 16'h0100, 3);
    repeat (4) cyc(0, 1, 0, 0, 0);
    pin("zero_pend", 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);          pin("zero_exit", 0, 3, 0, 0, 1);

    // Longer directed run with odd increments, pauses and gated requests
    cyc(0, 0, 1, 16'h1357, 250);
    for (int i = 0; i < 150; i++) begin
      if (i == 40 || i == 41)
        cyc(0, (i % 9) != 4, 1, 16'h2468, 7);
      else if (i == 90)
        cyc(0, (i % 9) != 4, 1, 16'hFFFF, 128);
      else
        cyc(0, (i % 9) != 4, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
